// File: rtl/fft_bfly_scheduler.sv
// Address/strobe sequencer for one shared radix-2 DIT butterfly over an in-place N-point FFT.
// Holds no sample data; every output is registered and decoded from the upcoming state.
module fft_bfly_scheduler #(
  parameter int N     = 8,
  parameter int LOG2N = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stall,
  output logic             busy,
  output logic             done,
  output logic             rd_en,
  output logic [LOG2N-1:0] addr_a,
  output logic [LOG2N-1:0] addr_b,
  output logic [LOG2N-2:0] tw_idx,
  output logic             mul_en,
  output logic             wr_en,
  output logic [LOG2N-1:0] stage
);

  localparam int BW = LOG2N - 1;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RD   = 3'd1;
  localparam logic [2:0] S_MUL  = 3'd2;
  localparam logic [2:0] S_WR   = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam logic [BW-1:0]    LAST_BFLY  = {BW{1'b1}};
  localparam logic [BW-1:0]    ONE_B      = BW'(1);
  localparam logic [LOG2N-1:0] ONE_A      = LOG2N'(1);
  localparam logic [LOG2N-1:0] LAST_STAGE = LOG2N'(LOG2N - 1);
  localparam logic [LOG2N-1:0] TOP_SHIFT  = LOG2N'(LOG2N - 1);

  if (N < 4 || N != (1 << LOG2N)) begin : g_bad_param
    $error("fft_bfly_scheduler: N must be a power of two >= 4 and LOG2N must equal log2(N)");
  end

  logic [2:0]       r_state;
  logic [LOG2N-1:0] r_stage;
  logic [BW-1:0]    r_bfly;

  logic             r_busy;
  logic             r_done;
  logic             r_rd_en;
  logic             r_mul_en;
  logic             r_wr_en;
  logic [LOG2N-1:0] r_addr_a;
  logic [LOG2N-1:0] r_addr_b;
  logic [BW-1:0]    r_tw_idx;
  logic [LOG2N-1:0] r_stage_out;

  logic [2:0]       w_state_nxt;
  logic [LOG2N-1:0] w_stage_nxt;
  logic [BW-1:0]    w_bfly_nxt;

  logic             w_in_bfly;
  logic [BW-1:0]    w_mask;
  logic [BW-1:0]    w_pos;
  logic [BW-1:0]    w_tw;
  logic [LOG2N-1:0] w_grp;
  logic [LOG2N-1:0] w_span;
  logic [LOG2N-1:0] w_addr_a;
  logic [LOG2N-1:0] w_addr_b;

  // Stall freezes everything except IDLE, where a start is still accepted.
  always_comb begin
    // NOTE: every signal gets a default up front so no path through the case infers a latch.
    w_state_nxt = r_state;
    w_stage_nxt = r_stage;
    w_bfly_nxt  = r_bfly;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_RD;
          w_stage_nxt = '0;
          w_bfly_nxt  = '0;
        end
      end
      S_RD:  if (!stall) w_state_nxt = S_MUL;
      S_MUL: if (!stall) w_state_nxt = S_WR;
      S_WR: begin
        if (!stall) begin
          if (r_bfly == LAST_BFLY) begin
            w_bfly_nxt = '0;
            if (r_stage == LAST_STAGE) begin
              w_state_nxt = S_DONE;
              w_stage_nxt = '0;
            end else begin
              w_state_nxt = S_RD;
              w_stage_nxt = r_stage + ONE_A;
            end
          end else begin
            w_state_nxt = S_RD;
            w_bfly_nxt  = r_bfly + ONE_B;
          end
        end
      end
      S_DONE:  if (!stall) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // span = 1<<s, pos = b mod span, grp = b div span; a = grp*2*span + pos, tw = pos * N/(2*span).
  // At the last stage 1<<s overflows BW bits to 0, so the mask correctly becomes all ones.
  always_comb begin
    w_in_bfly = (w_state_nxt == S_RD) || (w_state_nxt == S_MUL) || (w_state_nxt == S_WR);
    w_mask    = (ONE_B << w_stage_nxt) - ONE_B;
    w_pos     = w_bfly_nxt & w_mask;
    w_grp     = {1'b0, w_bfly_nxt} >> w_stage_nxt;
    w_span    = ONE_A << w_stage_nxt;
    w_addr_a  = ((w_grp << w_stage_nxt) << 1) | {1'b0, w_pos};
    w_addr_b  = w_addr_a | w_span;
    w_tw      = w_pos << (TOP_SHIFT - w_stage_nxt);
  end

  // Address fields read as zero outside a butterfly so IDLE/DONE look exactly like reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_stage     <= '0;
      r_bfly      <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_rd_en     <= 1'b0;
      r_mul_en    <= 1'b0;
      r_wr_en     <= 1'b0;
      r_addr_a    <= '0;
      r_addr_b    <= '0;
      r_tw_idx    <= '0;
      r_stage_out <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      r_state     <= w_state_nxt;
      r_stage     <= w_stage_nxt;
      r_bfly      <= w_bfly_nxt;
      r_busy      <= (w_state_nxt != S_IDLE);
      r_done      <= (w_state_nxt == S_DONE);
      r_rd_en     <= (w_state_nxt == S_RD);
      r_mul_en    <= (w_state_nxt == S_MUL);
      r_wr_en     <= (w_state_nxt == S_WR);
      r_addr_a    <= w_in_bfly ? w_addr_a : '0;
      r_addr_b    <= w_in_bfly ? w_addr_b : '0;
      r_tw_idx    <= w_in_bfly ? w_tw : '0;
      r_stage_out <= w_in_bfly ? w_stage_nxt : '0;
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign rd_en  = r_rd_en;
  assign mul_en = r_mul_en;
  assign wr_en  = r_wr_en;
  assign addr_a = r_addr_a;
  assign addr_b = r_addr_b;
  assign tw_idx = r_tw_idx;
  assign stage  = r_stage_out;

endmodule

// File: tb/tb_fft_bfly_scheduler.sv
// Bench for fft_bfly_scheduler: per-cycle comparison against a butterfly-list model, directed
// literal expectations, an end-to-end impulse FFT through a bench RAM/butterfly, and an N=16 build.
module tb_fft_bfly_scheduler;

  localparam int N     = 8;
  localparam int LOG2N = 3;
  localparam int HALF  = N / 2;
  localparam int NBF   = HALF * LOG2N;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic stall = 1'b0;
  logic busy, done, rd_en, mul_en, wr_en;
  logic [LOG2N-1:0] addr_a, addr_b, stage;
  logic [LOG2N-2:0] tw_idx;

  logic start16 = 1'b0;
  logic stall16 = 1'b0;
  logic b16_busy, b16_done, b16_rd, b16_mul, b16_wr;
  logic [3:0] b16_a, b16_b, b16_stage;
  logic [2:0] b16_tw;

  always #5 clk = ~clk;

  fft_bfly_scheduler #(.N(N), .LOG2N(LOG2N)) u_dut (
    .clk(clk), .rst(rst), .start(start), .stall(stall),
    .busy(busy), .done(done), .rd_en(rd_en), .addr_a(addr_a), .addr_b(addr_b),
    .tw_idx(tw_idx), .mul_en(mul_en), .wr_en(wr_en), .stage(stage)
  );

  fft_bfly_scheduler #(.N(16), .LOG2N(4)) u_dut16 (
    .clk(clk), .rst(rst), .start(start16), .stall(stall16),
    .busy(b16_busy), .done(b16_done), .rd_en(b16_rd), .addr_a(b16_a), .addr_b(b16_b),
    .tw_idx(b16_tw), .mul_en(b16_mul), .wr_en(b16_wr), .stage(b16_stage)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // ---------------- model: a flat list of butterflies, each taking RD, MUL, WR ----------------
  // m_j indexes butterflies in execution order; m_ph 0/1/2 = RD/MUL/WR, 3 = DONE.
  bit m_act = 1'b0;
  int m_j   = 0;
  int m_ph  = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_act <= 1'b0;
      m_j   <= 0;
      m_ph  <= 0;
    end else if (!m_act) begin
      if (start) begin
        m_act <= 1'b1;
        m_j   <= 0;
        m_ph  <= 0;
      end
    end else if (!stall) begin
      if (m_ph == 3)            m_act <= 1'b0;
      else if (m_ph < 2)        m_ph <= m_ph + 1;
      else if (m_j == NBF - 1)  m_ph <= 3;
      else begin
        m_j  <= m_j + 1;
        m_ph <= 0;
      end
    end
  end

  function automatic int f_stage(int j); return j / HALF; endfunction
  function automatic int f_span(int j);  return 1 << f_stage(j); endfunction
  function automatic int f_pos(int j);   return (j % HALF) % f_span(j); endfunction
  function automatic int f_a(int j);
    return ((j % HALF) / f_span(j)) * 2 * f_span(j) + f_pos(j);
  endfunction
  function automatic int f_tw(int j);    return f_pos(j) * (N / (2 * f_span(j))); endfunction

  always @(negedge clk) begin
    check("cyc busy",  busy,   m_act);
    check("cyc done",  done,   m_act && m_ph == 3);
    check("cyc rd_en", rd_en,  m_act && m_ph == 0);
    check("cyc mul_en", mul_en, m_act && m_ph == 1);
    check("cyc wr_en", wr_en,  m_act && m_ph == 2);
    if (m_act && m_ph < 3) begin
      check("cyc addr_a", addr_a, f_a(m_j));
      check("cyc addr_b", addr_b, f_a(m_j) + f_span(m_j));
      check("cyc tw_idx", tw_idx, f_tw(m_j));
      check("cyc stage",  stage,  f_stage(m_j));
    end
  end

  // ---------------- sample RAM (read latency 1) and Q1.15 butterfly driven by the DUT ----------
  logic signed [15:0] mem_re [N];
  logic signed [15:0] mem_im [N];
  int qa_re, qa_im, qb_re, qb_im, ya_re, ya_im, yb_re, yb_im;
  int twr [HALF] = '{32767, 23170, 0, -23170};
  int twi [HALF] = '{0, -23170, -32768, -23170};

  function automatic int mulq(int x, int y); return (x * y) >>> 15; endfunction

  always @(posedge clk) begin
    if (!stall) begin
      if (rd_en) begin
        qa_re <= mem_re[addr_a]; qa_im <= mem_im[addr_a];
        qb_re <= mem_re[addr_b]; qb_im <= mem_im[addr_b];
      end
      if (mul_en) begin
        ya_re <= qa_re + (mulq(qb_re, twr[tw_idx]) - mulq(qb_im, twi[tw_idx]));
        ya_im <= qa_im + (mulq(qb_re, twi[tw_idx]) + mulq(qb_im, twr[tw_idx]));
        yb_re <= qa_re - (mulq(qb_re, twr[tw_idx]) - mulq(qb_im, twi[tw_idx]));
        yb_im <= qa_im - (mulq(qb_re, twi[tw_idx]) + mulq(qb_im, twr[tw_idx]));
      end
      if (wr_en) begin
        mem_re[addr_a] <= 16'(ya_re); mem_im[addr_a] <= 16'(ya_im);
        mem_re[addr_b] <= 16'(yb_re); mem_im[addr_b] <= 16'(yb_im);
      end
    end
  end

  // ---------------- directed run helper ----------------
  typedef struct { int a; int b; int tw; int rd; int mul; } snap_t;
  snap_t wr_q[$];
  snap_t snap;

  // Cycle 0 is the cycle start is presented; cycle k is k edges later. stall is high in
  // cycles [st_at, st_at+st_len). Returns when DONE has passed and busy is low again.
  task automatic run8(input int st_at, input int st_len, input bit hold, input int snap_k,
                      output int done_k, output int busy_n, output int done_n);
    bit seen = 1'b0;
    done_k = -1; busy_n = 0; done_n = 0;
    wr_q.delete();
    @(negedge clk);
    start = 1'b1;
    stall = (st_at == 0 && st_len > 0);
    for (int k = 1; k <= 150; k++) begin
      @(negedge clk);
      if (!hold) start = 1'b0;
      if (busy) busy_n++;
      if (done) begin
        done_n++;
        if (done_k < 0) done_k = k;
        seen = 1'b1;
      end
      if (wr_en) wr_q.push_back('{int'(addr_a), int'(addr_b), int'(tw_idx), 0, 0});
      if (k == snap_k) snap = '{int'(addr_a), int'(addr_b), int'(tw_idx), int'(rd_en), int'(mul_en)};
      stall = (st_len > 0 && k >= st_at && k < st_at + st_len);
      if (seen && !busy) break;
    end
    stall = 1'b0;
  endtask

  int lit_a  [12] = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
  int lit_b  [12] = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
  int lit_tw [12] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int dk, bn, dn, got, strobes, ln;
    int la, lb, ltw, lst;

    // Reset state
    #2;
    check("reset busy", busy, 0);
    check("reset addr_b", addr_b, 0);
    check("reset stage", stage, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // T2: address sequence, done cycle, busy span (36 butterfly cycles + DONE)
    run8(-1, 0, 1'b0, 0, dk, bn, dn);
    check("t2 done cycle", dk, 37);
    check("t2 busy cycles", bn, 37);
    check("t2 done pulse len", dn, 1);
    check("t2 wr count", wr_q.size(), 12);
    for (int i = 0; i < 12 && i < wr_q.size(); i++) begin
      check($sformatf("t2 bfly%0d a", i), wr_q[i].a, lit_a[i]);
      check($sformatf("t2 bfly%0d b", i), wr_q[i].b, lit_b[i]);
      check($sformatf("t2 bfly%0d tw", i), wr_q[i].tw, lit_tw[i]);
    end

    // T1: async reset in WR of stage 1, then a clean full run
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    got = 0;
    for (int k = 0; k < 60; k++) begin
      if (wr_en && stage == 1) begin got = 1; break; end
      @(negedge clk);
    end
    check("t1 reached stage1 WR", got, 1);
    #1 rst = 1'b1;
    #1;
    check("t1 busy", busy, 0);
    check("t1 done", done, 0);
    check("t1 rd_en", rd_en, 0);
    check("t1 mul_en", mul_en, 0);
    check("t1 wr_en", wr_en, 0);
    check("t1 addr_a", addr_a, 0);
    check("t1 addr_b", addr_b, 0);
    check("t1 tw_idx", tw_idx, 0);
    check("t1 stage", stage, 0);
    @(negedge clk);
    rst = 1'b0;
    run8(-1, 0, 1'b0, 0, dk, bn, dn);
    check("t1 rerun done cycle", dk, 37);
    check("t1 rerun busy cycles", bn, 37);

    // T4: 5-cycle stall in MUL of stage 1, butterfly 2
    run8(20, 5, 1'b0, 22, dk, bn, dn);
    check("t4 stalled mul_en", snap.mul, 1);
    check("t4 stalled addr_a", snap.a, 4);
    check("t4 stalled addr_b", snap.b, 6);
    check("t4 stalled tw", snap.tw, 0);
    check("t4 done cycle", dk, 42);

    // Stall in DONE holds done until stall drops
    run8(37, 2, 1'b0, 0, dk, bn, dn);
    check("done-stall first done", dk, 37);
    check("done-stall done len", dn, 3);

    // Stall in IDLE is ignored: start still moves to RD, then stall freezes RD
    run8(0, 3, 1'b0, 1, dk, bn, dn);
    check("idle-stall rd_en", snap.rd, 1);
    check("idle-stall done cycle", dk, 39);

    // T3: start held high -> one IDLE cycle between back-to-back transforms
    run8(-1, 0, 1'b1, 0, dk, bn, dn);
    check("t3 first done", dk, 37);
    @(negedge clk);
    check("t3 busy after 1 idle", busy, 1);
    check("t3 rd after 1 idle", rd_en, 1);
    start = 1'b0;
    got = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (done) begin got = 1; break; end
    end
    check("t3 second done seen", got, 1);
    @(negedge clk);

    // T5: impulse through RAM and butterfly
    for (int i = 0; i < N; i++) begin
      mem_re[i] = '0;
      mem_im[i] = '0;
    end
    mem_re[0] = 16'sh7FFF;
    run8(-1, 0, 1'b0, 0, dk, bn, dn);
    for (int i = 0; i < N; i++) begin
      int v;
      v = mem_re[i];
      check($sformatf("t5 X%0d re within 1 LSB of 32767 (value %0d)", i, v),
            (v >= 32766 && v <= 32768), 1);
      check($sformatf("t5 X%0d im", i), int'(mem_im[i]), 0);
    end

    // T6: N=16 build
    @(negedge clk);
    start16 = 1'b1;
    dk = -1; bn = 0; strobes = 0; ln = 0;
    la = -1; lb = -1; ltw = -1; lst = -1;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      start16 = 1'b0;
      if (b16_busy) bn++;
      if (b16_rd || b16_mul || b16_wr) strobes++;
      if (b16_wr) begin la = b16_a; lb = b16_b; ltw = b16_tw; lst = b16_stage; ln++; end
      if (b16_done) begin dk = k; break; end
    end
    check("t6 butterfly cycles", strobes, 96);
    check("t6 busy incl done", bn, 97);
    check("t6 done cycle", dk, 97);
    check("t6 butterflies", ln, 32);
    check("t6 last a", la, 7);
    check("t6 last b", lb, 15);
    check("t6 last tw", ltw, 7);
    check("t6 last stage", lst, 3);

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
